// File: rtl/uart_tx_fifo_drain.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_drain
//
// UART transmitter that drains a fall-through TX FIFO. Whenever the block is
// idle and the FIFO reports data, the head word is popped and serialised as
// one frame: a start bit, DBIT data bits LSB first, an optional even-parity
// bit, then the stop period. Bit timing comes from an external 16x
// oversampling baud tick, so one bit lasts 16 ticks.
//
// Build option:
//   UART_TX_PARITY_EN  when defined, an even-parity bit is inserted between
//                      the last data bit and the stop period. The parity is
//                      computed from the word at pop time.
//
// Parameters:
//   DBIT     data bits per frame (5..8)
//   SB_TICK  baud ticks in the stop period (16 = 1, 24 = 1.5, 32 = 2 stops)
//
// Ports:
//   i_clk         system clock, rising edge
//   i_reset_n     asynchronous active-low reset
//   i_tick        baud tick, one-cycle pulse at 16x the bit rate
//   i_fifo_empty  FIFO empty flag
//   i_fifo_data   FIFO head word, valid while i_fifo_empty is low
//   o_fifo_rd     FIFO pop strobe, one cycle, only from IDLE
//   o_tx          serial line, idle high, registered
//   o_busy        high while a frame is in progress
//   o_tx_done     one-cycle pulse on the last tick of the stop period
// -----------------------------------------------------------------------------
module uart_tx_fifo_drain #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_tick,
  input  logic            i_fifo_empty,
  input  logic [DBIT-1:0] i_fifo_data,
  output logic            o_fifo_rd,
  output logic            o_tx,
  output logic            o_busy,
  output logic            o_tx_done
);

  // The tick counter must reach SB_TICK-1 in the stop period (31 for two stop
  // bits), so it grows beyond 4 bits when the stop period is longer than 16.
  localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;

  // State encoding kept as plain constants for compatibility with existing
  // tooling that decodes the state register directly.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic [SW-1:0] S_BIT_LAST  = SW'(15);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [2:0]    N_LAST      = 3'(DBIT - 1);

  logic [2:0]      state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [2:0]      n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            tx_q, tx_d;
  logic            fifo_rd;
  logic            tx_done;

`ifdef UART_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    fifo_rd = 1'b0;
    tx_done = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // Start as soon as a word is available; the tick phase does not
        // matter because the start bit counts its own 16 ticks.
        if (!i_fifo_empty) begin
          fifo_rd = 1'b1;
          b_d     = i_fifo_data;
          s_d     = '0;
          state_d = ST_START;
`ifdef UART_TX_PARITY_EN
          par_d   = ^i_fifo_data;
`endif
        end
      end

      ST_START: begin
        if (i_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d     = '0;
            n_d     = '0;
            state_d = ST_DATA;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

      ST_DATA: begin
        if (i_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == N_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end else begin
              n_d = n_q + 3'd1;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (i_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d     = '0;
            state_d = ST_STOP;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
`endif

      ST_STOP: begin
        // Done is decoded combinationally on the final stop tick so the very
        // next cycle is IDLE and can pop again: frames are one clock apart.
        if (i_tick) begin
          if (s_q == S_STOP_LAST) begin
            tx_done = 1'b1;
            state_d = ST_IDLE;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Line level for the current state. It is registered below, so o_tx follows
  // the state one clock later and cannot glitch on decode transitions.
  // ---------------------------------------------------------------------------
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      ST_IDLE:   tx_d = 1'b1;
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = b_q[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = par_q;
`endif
      ST_STOP:   tx_d = 1'b1;
      default:   tx_d = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      // Reset aborts any frame in flight and forces the line high at once.
      state_q <= ST_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign o_fifo_rd = fifo_rd;
  assign o_tx      = tx_q;
  assign o_busy    = (state_q != ST_IDLE);
  assign o_tx_done = tx_done;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo_drain
//
// Self-checking bench for uart_tx_fifo_drain. A frame model counts baud ticks
// since the pop and derives the line level from the tick index (16 ticks per
// bit), compared against the DUT every clock. Directed scenarios pin the model
// with literal expectations; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo_drain;

  localparam int DBIT    = 8;
  localparam int SB_TICK = 16;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int TOTAL = 16 * (1 + DBIT + PAR) + SB_TICK;

  logic            i_clk = 1'b0;
  logic            i_reset_n = 1'b0;
  logic            i_tick = 1'b0;
  logic            i_fifo_empty = 1'b1;
  logic [DBIT-1:0] i_fifo_data = '0;
  logic            o_fifo_rd;
  logic            o_tx;
  logic            o_busy;
  logic            o_tx_done;

  uart_tx_fifo_drain #(.DBIT(DBIT), .SB_TICK(SB_TICK)) dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_tick       (i_tick),
    .i_fifo_empty (i_fifo_empty),
    .i_fifo_data  (i_fifo_data),
    .o_fifo_rd    (o_fifo_rd),
    .o_tx         (o_tx),
    .o_busy       (o_busy),
    .o_tx_done    (o_tx_done)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 20)
        $display("FAIL %s: got %0h expected %0h (time %0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // FIFO contents and tick generation
  // ---------------------------------------------------------------------------
  logic [DBIT-1:0] fifo_q[$];
  int tick_mode = 1;   // 0: random ticks, N>0: one tick every N cycles
  int tick_ph   = 0;

  task automatic drive_fifo();
    i_fifo_empty = (fifo_q.size() == 0);
    i_fifo_data  = i_fifo_empty ? DBIT'($urandom) : fifo_q[0];
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
    if (tick_mode == 0) begin
      i_tick = ($urandom_range(0, 1) == 1);
    end else begin
      i_tick = ((tick_ph % tick_mode) == 0);
      tick_ph++;
    end
    drive_fifo();
  endtask

  // ---------------------------------------------------------------------------
  // Frame model: position in the frame is just the number of ticks seen since
  // the pop; the line level is a function of that index.
  // ---------------------------------------------------------------------------
  logic            m_busy  = 1'b0;
  int              m_ticks = 0;
  logic [DBIT-1:0] m_word  = '0;
  logic            m_txq   = 1'b1;
  int              cyc     = 0;

  function automatic logic line_level(input int t, input logic [DBIT-1:0] w);
    int seg;
    seg = t / 16;
    if (seg == 0) return 1'b0;
    if (seg <= DBIT) return w[seg-1];
    if (PAR == 1 && seg == DBIT + 1) return ^w;
    return 1'b1;
  endfunction

  always @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      m_busy  <= 1'b0;
      m_ticks <= 0;
      m_txq   <= 1'b1;
    end else begin
      cyc   <= cyc + 1;
      m_txq <= m_busy ? line_level(m_ticks, m_word) : 1'b1;
      if (!m_busy) begin
        if (!i_fifo_empty) begin
          m_busy  <= 1'b1;
          m_word  <= i_fifo_data;
          m_ticks <= 0;
          void'(fifo_q.pop_front());
        end
      end else if (i_tick) begin
        if (m_ticks == TOTAL - 1) m_busy <= 1'b0;
        else                      m_ticks <= m_ticks + 1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle compare, plus event stamps used by the directed checks
  // ---------------------------------------------------------------------------
  logic tx_hist[int];
  int   rd_seen = 0, done_seen = 0;
  int   last_rd_cyc = 0, last_done_cyc = 0;

  always @(negedge i_clk) begin
    if (i_reset_n) begin
      check("tx",   {31'd0, o_tx},      {31'd0, m_txq});
      check("busy", {31'd0, o_busy},    {31'd0, m_busy});
      check("rd",   {31'd0, o_fifo_rd}, {31'd0, (!m_busy && !i_fifo_empty)});
      check("done", {31'd0, o_tx_done}, {31'd0, (m_busy && i_tick && m_ticks == TOTAL - 1)});
      tx_hist[cyc] = o_tx;
      if (o_fifo_rd) begin rd_seen++;   last_rd_cyc   = cyc; end
      if (o_tx_done) begin done_seen++; last_done_cyc = cyc; end
    end
  end

  task automatic wait_done(input int budget, input string name);
    int d0, k;
    d0 = done_seen;
    k  = 0;
    while (done_seen == d0 && k < budget) begin
      step();
      k++;
    end
    check(name, done_seen - d0, 1);
  endtask

  task automatic pulse_reset(input int hold);
    #2 i_reset_n = 1'b0;
    #1;
    check("rst_tx_async",  {31'd0, o_tx},      32'd1);
    check("rst_busy",      {31'd0, o_busy},    32'd0);
    check("rst_done",      {31'd0, o_tx_done}, 32'd0);
    repeat (hold) step();
    i_reset_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int pin_a5[11];
  int r0, d0, first_done, low, lo, hi;

  initial begin
    // Reset state while held.
    tick_mode = 1;
    repeat (3) step();
    check("reset_tx",   {31'd0, o_tx},      32'd1);
    check("reset_busy", {31'd0, o_busy},    32'd0);
    check("reset_rd",   {31'd0, o_fifo_rd}, 32'd0);
    check("reset_done", {31'd0, o_tx_done}, 32'd0);
    i_reset_n = 1'b1;

    // Idle with an empty FIFO and random ticks: nothing must happen.
    tick_mode = 0;
    repeat (500) step();
    check("idle_no_pop", rd_seen, 0);
    check("idle_tx", {31'd0, o_tx}, 32'd1);

    // Single frame 0xA5, tick every clock.
    tick_mode = 1;
    r0 = rd_seen;
    fifo_q.push_back(8'hA5);
    drive_fifo();
    wait_done(400, "a5_done_timeout");
    check("a5_one_pop", rd_seen - r0, 1);
    check("a5_frame_len", last_done_cyc - last_rd_cyc, PAR ? 176 : 160);
    // Start, LSB-first 1,0,1,0,0,1,0,1, (even parity 0), stop.
    pin_a5 = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1};
    if (PAR == 1) begin
      pin_a5[9]  = 0;
      pin_a5[10] = 1;
    end
    for (int k = 0; k < 10 + PAR; k++)
      check($sformatf("a5_bit%0d", k),
            {31'd0, tx_hist[last_rd_cyc + 2 + 16 * k + 8]}, pin_a5[k]);
    repeat (5) step();

    // Word 0x00 with a tick every 4th clock.
    tick_mode = 4;
    d0 = done_seen;
    fifo_q.push_back(8'h00);
    drive_fifo();
    wait_done(4 * TOTAL + 100, "zero_done_timeout");
    check("zero_one_done", done_seen - d0, 1);
    low = 0;
    for (int c = last_rd_cyc + 1; c <= last_done_cyc; c++)
      if (tx_hist.exists(c) && tx_hist[c] == 1'b0) low++;
    // 144 low ticks (160 with parity), first tick 0..3 clocks after the pop.
    lo = PAR ? 637 : 573;
    hi = PAR ? 640 : 576;
    check("zero_low_cycles", {31'd0, (low >= lo && low <= hi)}, 32'd1);
    repeat (5) step();

    // Back-to-back frames 0x55, 0x0F.
    tick_mode = 1;
    r0 = rd_seen;
    fifo_q.push_back(8'h55);
    fifo_q.push_back(8'h0F);
    drive_fifo();
    wait_done(400, "b2b_first_timeout");
    first_done = last_done_cyc;
    wait_done(400, "b2b_second_timeout");
    check("b2b_two_pops", rd_seen - r0, 2);
    check("b2b_gap", last_rd_cyc - first_done, 1);
    check("b2b_fifo_empty", fifo_q.size(), 0);
    step();
    check("b2b_idle", {31'd0, o_busy}, 32'd0);

    // Reset during data bit 3 of 0xC3 (bit 3 is 0, so the line is low).
    r0 = rd_seen;
    fifo_q.push_back(8'hC3);
    drive_fifo();
    for (int k = 0; k < 20 && rd_seen == r0; k++) step();
    check("mid_pop", rd_seen - r0, 1);
    repeat (17 + 48 + 4) step();
    check("mid_line_low", {31'd0, o_tx}, 32'd0);
    d0 = done_seen;
    r0 = rd_seen;
    pulse_reset(3);
    repeat (100) step();
    check("mid_no_done", done_seen - d0, 0);
    check("mid_no_pop", rd_seen - r0, 0);
    check("mid_idle", {31'd0, o_busy}, 32'd0);

`ifdef UART_TX_PARITY_EN
    // Parity of 0x07 is 1 and lasts one bit time before the stop period.
    fifo_q.push_back(8'h07);
    drive_fifo();
    wait_done(400, "par_done_timeout");
    check("par_frame_len", last_done_cyc - last_rd_cyc, 176);
    check("par_bit", {31'd0, tx_hist[last_rd_cyc + 2 + 16 * 9 + 8]}, 32'd1);
    check("par_stop", {31'd0, tx_hist[last_rd_cyc + 2 + 16 * 10 + 8]}, 32'd1);
    repeat (3) step();
`endif

    // Randomized traffic, tick rates and occasional resets.
    for (int it = 0; it < 30; it++) begin
      tick_mode = $urandom_range(0, 3);
      for (int p = $urandom_range(0, 2); p > 0; p--)
        fifo_q.push_back(DBIT'($urandom));
      drive_fifo();
      repeat ($urandom_range(50, 400)) step();
      if ($urandom_range(0, 9) == 0) pulse_reset($urandom_range(1, 4));
    end
    tick_mode = 1;
    for (int k = 0; k < 40000 && (o_busy || fifo_q.size() != 0); k++) step();
    check("drain_empty", fifo_q.size(), 0);
    check("drain_idle", {31'd0, o_busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
